// File: rtl/rv_pkg.sv
// Shared fetch-stage definitions: next-PC select encodings, fetch FSM states, nop word.
package rv_pkg;

   localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
   localparam logic [1:0] PCSRC_TARGET = 2'b01;
   localparam logic [1:0] PCSRC_ALU    = 2'b10;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      HOLD = 2'b10
   } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC select and alignment handling for the fetch stage.
// Build option MISALIGN_TRAP_EN: misaligned next PC redirects to TRAP_PC instead of being forced aligned.
module pc_next
   import rv_pkg::*;
#(
   parameter int unsigned N = 32
`ifdef MISALIGN_TRAP_EN
   ,
   parameter logic [N-1:0] TRAP_PC = N'(32'h0000_0100)
`endif
) (
   input  logic [N-1:0] pc_plus4_i,
   input  logic [1:0]   pcsrc_i,
   input  logic [N-1:0] pc_target_i,
   input  logic [N-1:0] alu_result_i,
   output logic [N-1:0] next_pc_o,
   output logic         trap_o
);

   logic [N-1:0] sel_pc;

   always_comb begin
      // NOTE: default assignment first so every path drives sel_pc and no latch is inferred.
      sel_pc = pc_plus4_i;
      case (pcsrc_i)
         PCSRC_PLUS4:  sel_pc = pc_plus4_i;
         PCSRC_TARGET: sel_pc = pc_target_i;
         // jalr target has bit 0 cleared before alignment is judged
         PCSRC_ALU:    sel_pc = alu_result_i & {{(N-1){1'b1}}, 1'b0};
         default:      sel_pc = pc_plus4_i;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   assign trap_o    = (sel_pc[1:0] != 2'b00);
   assign next_pc_o = trap_o ? TRAP_PC : sel_pc;
`else
   assign trap_o    = 1'b0;
   assign next_pc_o = sel_pc & {{(N-2){1'b1}}, 2'b00};
`endif

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: IDLE/REQ/HOLD handshake FSM holding PC and the fetched instruction.
// Build option MISALIGN_TRAP_EN enables the misaligned-PC trap and the misalign pulse.
module pc_fetch
   import rv_pkg::*;
#(
   parameter int unsigned  N        = 32,
   parameter logic [N-1:0] RESET_PC = N'(32'h0000_0000),
   parameter logic [N-1:0] TRAP_PC  = N'(32'h0000_0100)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [1:0]   PCSrc,
   input  logic [N-1:0] PCTarget,
   input  logic [N-1:0] ALUResult,
   input  logic         instr_ready,
   input  logic         imem_ack,
   input  logic [31:0]  imem_rdata,
   output logic         imem_req,
   output logic [N-1:0] imem_addr,
   output logic         instr_valid,
   output logic [31:0]  Instr,
   output logic [N-1:0] PC,
   output logic [N-1:0] PCPlus4,
   output logic         misalign
);

   fetch_state_t state_q, state_d;
   logic [N-1:0] pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic         misalign_q, misalign_d;
   logic [N-1:0] pc_plus4;
   logic [N-1:0] next_pc;
   logic         trap;

   assign pc_plus4 = pc_q + N'(4);

   pc_next #(
      .N       (N)
`ifdef MISALIGN_TRAP_EN
      ,
      .TRAP_PC (TRAP_PC)
`endif
   ) u_pc_next (
      .pc_plus4_i   (pc_plus4),
      .pcsrc_i      (PCSrc),
      .pc_target_i  (PCTarget),
      .alu_result_i (ALUResult),
      .next_pc_o    (next_pc),
      .trap_o       (trap)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      misalign_d = 1'b0;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = HOLD;
            end
         end
         HOLD: begin
            // retire cycle: the only place the next-PC inputs are consumed
            if (instr_ready) begin
               pc_d       = next_pc;
               misalign_d = trap;
               state_d    = REQ;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         instr_q    <= NOP;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         misalign_q <= misalign_d;
      end
   end

   assign imem_req    = (state_q == REQ);
   assign imem_addr   = pc_q;
   assign instr_valid = (state_q == HOLD);
   assign Instr       = instr_q;
   assign PC          = pc_q;
   assign PCPlus4     = pc_plus4;
   assign misalign    = misalign_q;

endmodule
